// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory port signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req_valid;
    logic [ADDR_W-1:0]     i_req_addr;
    logic                  i_req_ready;
    logic                  i_resp_valid;
    logic [DATA_W-1:0]     i_resp_rdata;

    logic                  d_req_valid;
    logic                  d_req_we;
    logic [ADDR_W-1:0]     d_req_addr;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_wstrb;
    logic                  d_req_ready;
    logic                  d_resp_valid;
    logic [DATA_W-1:0]     d_resp_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_rdata;

    logic                  busy;
    logic                  owner_d;

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_rdata,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_resp_valid, d_resp_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output busy, owner_d
    );

    // Requesters and memory side
    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_rdata,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_resp_valid, d_resp_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  busy, owner_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding D-over-I memory port arbiter, optional starvation guard MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                owner_d_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                grant_d;
    logic                grant_i;
    logic                force_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign force_i = bus.i_req_valid && (starve_cnt == CNT_W'(STARVE_MAX));

    // Count D grants taken while I waits; any I grant clears the count
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.i_req_valid && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Without the guard the threshold can never be met, so I is never forced
    assign force_i = (STARVE_MAX < 0);
`endif

    // Winner selection, only in IDLE and never while reset is applied
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if ((state == IDLE) && !rst) begin
            grant_d = bus.d_req_valid && !force_i;
            grant_i = bus.i_req_valid && !grant_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant -> issue until accepted -> wait for response -> release
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_i) state_nxt = ISSUE;
            ISSUE:   if (bus.mem_req_ready)  state_nxt = WAIT;
            WAIT:    if (bus.mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request; fetches always read with no byte enables
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (grant_d) begin
            owner_d_q <= 1'b1;
            we_q      <= bus.d_req_we;
            addr_q    <= bus.d_req_addr;
            wdata_q   <= bus.d_req_wdata;
            wstrb_q   <= bus.d_req_wstrb;
        end else if (grant_i) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= bus.i_req_addr;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end
    end

    // Outputs: ready pulses, memory request, response routed to the owner only
    always_comb begin
        bus.i_req_ready   = grant_i;
        bus.d_req_ready   = grant_d;
        bus.mem_req_valid = (state == ISSUE) && !rst;
        bus.mem_we        = we_q;
        bus.mem_addr      = addr_q;
        bus.mem_wdata     = wdata_q;
        bus.mem_wstrb     = wstrb_q;
        bus.i_resp_valid  = (state == WAIT) && !rst && bus.mem_resp_valid && !owner_d_q;
        bus.d_resp_valid  = (state == WAIT) && !rst && bus.mem_resp_valid && owner_d_q;
        bus.i_resp_rdata  = bus.mem_resp_rdata;
        bus.d_resp_rdata  = bus.mem_resp_rdata;
        bus.busy          = (state != IDLE) && !rst;
        bus.owner_d       = owner_d_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the ISSUE cycle: accept at once, respond one cycle later, back in IDLE after
    task automatic finish_txn(input logic [31:0] rd);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = rd;
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        bus.i_req_valid = 0; bus.i_req_addr = 0;
        bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = 0;
        bus.d_req_wdata = 0; bus.d_req_wstrb = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_rdata = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_busy",      64'(bus.busy), 0);
        check("rst_owner",     64'(bus.owner_d), 0);
        check("rst_mem_valid", 64'(bus.mem_req_valid), 0);
        check("rst_mem_addr",  64'(bus.mem_addr), 0);
        check("rst_mem_wstrb", 64'(bus.mem_wstrb), 0);
        check("rst_i_ready",   64'(bus.i_req_ready), 0);

        // Single fetch
        tick();
        bus.i_req_valid = 1; bus.i_req_addr = 32'h100;
        #1;
        check("f_i_ready",  64'(bus.i_req_ready), 1);
        check("f_d_ready",  64'(bus.d_req_ready), 0);
        tick();
        bus.i_req_valid = 0;
        bus.mem_req_ready = 1;
        #1;
        check("f_i_ready_pulse", 64'(bus.i_req_ready), 0);
        check("f_mem_valid", 64'(bus.mem_req_valid), 1);
        check("f_mem_addr",  64'(bus.mem_addr), 32'h100);
        check("f_mem_we",    64'(bus.mem_we), 0);
        check("f_busy",      64'(bus.busy), 1);
        check("f_owner",     64'(bus.owner_d), 0);
        tick();
        bus.mem_req_ready = 0;
        check("f_wait_mem_valid", 64'(bus.mem_req_valid), 0);
        bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'hDEADBEEF;
        #1;
        check("f_i_resp_valid", 64'(bus.i_resp_valid), 1);
        check("f_i_resp_rdata", 64'(bus.i_resp_rdata), 32'hDEADBEEF);
        check("f_d_resp_valid", 64'(bus.d_resp_valid), 0);
        tick();
        bus.mem_resp_valid = 0;
        #1;
        check("f_busy_low", 64'(bus.busy), 0);

        // Simultaneous I and D load: D first, then I
        bus.i_req_valid = 1; bus.i_req_addr = 32'h200;
        bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h400;
        #1;
        check("s_d_ready", 64'(bus.d_req_ready), 1);
        check("s_i_ready", 64'(bus.i_req_ready), 0);
        tick();
        bus.d_req_valid = 0;
        check("s_mem_addr_d", 64'(bus.mem_addr), 32'h400);
        check("s_owner_d",    64'(bus.owner_d), 1);
        bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'hCAFE0001;
        #1;
        check("s_d_resp_valid", 64'(bus.d_resp_valid), 1);
        check("s_d_resp_rdata", 64'(bus.d_resp_rdata), 32'hCAFE0001);
        check("s_i_resp_quiet", 64'(bus.i_resp_valid), 0);
        tick();
        bus.mem_resp_valid = 0;
        #1;
        check("s_i_ready2", 64'(bus.i_req_ready), 1);
        tick();
        bus.i_req_valid = 0;
        check("s_mem_addr_i", 64'(bus.mem_addr), 32'h200);
        check("s_mem_we_i",   64'(bus.mem_we), 0);
        check("s_mem_wstrb_i", 64'(bus.mem_wstrb), 0);
        check("s_owner_i",    64'(bus.owner_d), 0);
        finish_txn(32'h1);

        // Store with memory stalling for 3 cycles
        bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_addr = 32'h10;
        bus.d_req_wdata = 32'h12345678; bus.d_req_wstrb = 4'b0011;
        #1;
        check("st_d_ready", 64'(bus.d_req_ready), 1);
        tick();
        bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = 32'hFFFF;
        bus.d_req_wdata = 0; bus.d_req_wstrb = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("st_mem_valid", 64'(bus.mem_req_valid), 1);
            check("st_mem_addr",  64'(bus.mem_addr), 32'h10);
            check("st_mem_wdata", 64'(bus.mem_wdata), 32'h12345678);
            check("st_mem_wstrb", 64'(bus.mem_wstrb), 4'b0011);
            check("st_mem_we",    64'(bus.mem_we), 1);
            tick();
        end
        bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        check("st_wait_mem_valid", 64'(bus.mem_req_valid), 0);
        bus.mem_resp_valid = 1;
        #1;
        check("st_d_resp_valid", 64'(bus.d_resp_valid), 1);
        check("st_i_resp_valid", 64'(bus.i_resp_valid), 0);
        tick();
        bus.mem_resp_valid = 0;
        #1;
        check("st_d_resp_done", 64'(bus.d_resp_valid), 0);
        check("st_busy_low",    64'(bus.busy), 0);

        // Reset in WAIT, late response afterwards
        bus.i_req_valid = 1; bus.i_req_addr = 32'h300;
        tick();
        bus.i_req_valid = 0;
        bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0;
        check("r_in_wait_busy", 64'(bus.busy), 1);
        rst = 1;
        tick();
        rst = 0;
        bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'h55;
        #1;
        check("r_i_resp", 64'(bus.i_resp_valid), 0);
        check("r_d_resp", 64'(bus.d_resp_valid), 0);
        check("r_busy",   64'(bus.busy), 0);
        check("r_owner",  64'(bus.owner_d), 0);
        check("r_mem_valid", 64'(bus.mem_req_valid), 0);
        check("r_mem_addr",  64'(bus.mem_addr), 0);
        check("r_mem_we",    64'(bus.mem_we), 0);
        tick();
        check("r_still_idle", 64'(bus.busy), 0);
        bus.mem_resp_valid = 0;

        // Stray response in IDLE then in ISSUE
        bus.mem_resp_valid = 1;
        #1;
        check("x_idle_i_resp", 64'(bus.i_resp_valid), 0);
        check("x_idle_d_resp", 64'(bus.d_resp_valid), 0);
        tick();
        check("x_idle_busy", 64'(bus.busy), 0);
        bus.mem_resp_valid = 0;
        bus.d_req_valid = 1; bus.d_req_addr = 32'h44;
        tick();
        bus.d_req_valid = 0;
        bus.mem_resp_valid = 1;
        #1;
        check("x_issue_d_resp", 64'(bus.d_resp_valid), 0);
        tick();
        bus.mem_resp_valid = 0;
        check("x_issue_hold", 64'(bus.mem_req_valid), 1);
        finish_txn(32'h2);

        // Both requesters continuously valid: grant order
        bus.i_req_valid = 1; bus.i_req_addr = 32'h500;
        bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h600;
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_d = ((k % 5) != 4);
`else
            exp_d = 1'b1;
`endif
            #1;
            check("g_d_ready", 64'(bus.d_req_ready), 64'(exp_d));
            check("g_i_ready", 64'(bus.i_req_ready), 64'(!exp_d));
            tick();
            finish_txn(32'h3);
        end
        bus.i_req_valid = 0; bus.d_req_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
